// File: rtl/line_timing_monitor_if.sv
// line_timing_monitor_if: control inputs and status outputs of the endLine period monitor
interface line_timing_monitor_if;
  logic        i_mon_enb;
  logic        i_test;
  logic        i_end_line;
  logic [11:0] o_line_len;
  logic        o_line_valid;
  logic        o_len_err;
  logic        o_timeout;
  logic        o_locked;
  logic [7:0]  o_err_cnt;
  modport master (
    output i_mon_enb, i_test, i_end_line,
    input  o_line_len, o_line_valid, o_len_err, o_timeout, o_locked, o_err_cnt
  );
  modport slave (
    input  i_mon_enb, i_test, i_end_line,
    output o_line_len, o_line_valid, o_len_err, o_timeout, o_locked, o_err_cnt
  );
endinterface

// File: rtl/line_timing_monitor.sv
// line_timing_monitor: measures endLine spacing, flags length errors and timeouts, reports lock
module line_timing_monitor #(
  parameter int NORMAL_LEN = 4096,
  parameter int TEST_LEN   = 16,
  parameter int LOCK_LINES = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  line_timing_monitor_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SEEK, TRACK, LOCKED} state_t;
  localparam logic [11:0] NORM_M1 = 12'(NORMAL_LEN - 1);
  localparam logic [11:0] TEST_M1 = 12'(TEST_LEN - 1);
  localparam logic [4:0]  LOCK_N  = 5'(LOCK_LINES);
  state_t      r_state, w_next;
  logic [11:0] r_cyc, r_line_len, w_exp_m1;
  logic [3:0]  r_good;
  logic [7:0]  r_err_cnt;
  logic        r_test_q, r_line_valid, r_len_err, r_timeout, r_locked;
  logic        w_run, w_tchg, w_live, w_meas, w_match, w_tmo, w_lock, w_err;
  // state register
  always_ff @(posedge clk)
    r_state <= !rst_n ? IDLE : w_next;
  // next state: disable beats a test-mode change, which beats measurement and timeout
  always_comb
    w_next = !bus.i_mon_enb                    ? IDLE   :
             r_state == IDLE                   ? SEEK   :
             (w_tchg || w_tmo)                 ? SEEK   :
             (r_state == SEEK && bus.i_end_line) ? TRACK :
             w_lock                            ? LOCKED :
             (w_meas && !w_match)              ? TRACK  : r_state;
  // per-cycle events derived from the current state and inputs
  always_comb begin
    w_exp_m1 = bus.i_test ? TEST_M1 : NORM_M1;
    w_run    = r_state == TRACK || r_state == LOCKED;
    w_tchg   = r_state != IDLE && bus.i_test != r_test_q;
    w_live   = bus.i_mon_enb && !w_tchg;
    w_meas   = w_live && w_run && bus.i_end_line;
    w_match  = w_meas && r_cyc == w_exp_m1;
    w_tmo    = w_live && w_run && !bus.i_end_line && r_cyc == 12'hfff;
    w_lock   = w_match && (r_state == LOCKED || {1'b0, r_good} + 5'd1 >= LOCK_N);
    w_err    = (w_meas && !w_match) || w_tmo;
  end
  // measurement counter, good-line run, registered status and saturating error count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cyc        <= '0;
      r_good       <= '0;
      r_test_q     <= 1'b0;
      r_line_len   <= '0;
      r_line_valid <= 1'b0;
      r_len_err    <= 1'b0;
      r_timeout    <= 1'b0;
      r_locked     <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_test_q     <= bus.i_test;
      r_cyc        <= (w_run && w_live && !w_meas && !w_tmo) ? r_cyc + 12'd1 : 12'd0;
      r_good       <= (!w_live || r_state == IDLE || w_err) ? 4'd0 :
                      (w_match && r_state == TRACK) ? r_good + 4'd1 : r_good;
      r_line_valid <= w_meas;
      r_len_err    <= w_err;
      r_timeout    <= w_tmo;
      r_locked     <= w_next == LOCKED;
      if (w_meas)
        r_line_len <= r_cyc;
      if (w_err && r_err_cnt != 8'hff)
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end
  assign bus.o_line_len   = r_line_len;
  assign bus.o_line_valid = r_line_valid;
  assign bus.o_len_err    = r_len_err;
  assign bus.o_timeout    = r_timeout;
  assign bus.o_locked     = r_locked;
  assign bus.o_err_cnt    = r_err_cnt;
endmodule

// File: tb/tb_line_timing_monitor.sv
// tb_line_timing_monitor: directed checks of period measurement, lock, errors, timeout and reset
module tb_line_timing_monitor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0, n_fail = 0;
  int n_lv = 0, n_le = 0, n_to = 0, lv_at_lock = 0;
  int lv0, le0, to0;
  logic lock_q = 1'b0;
  logic [11:0] last_len = '0;
  line_timing_monitor_if bus();
  line_timing_monitor dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #8 clk = ~clk;
  // pulse bookkeeping sampled mid-cycle
  always @(negedge clk) begin
    if (bus.o_line_valid) begin
      n_lv <= n_lv + 1;
      last_len <= bus.o_line_len;
    end
    if (bus.o_len_err) n_le <= n_le + 1;
    if (bus.o_timeout) n_to <= n_to + 1;
    if (bus.o_locked && !lock_q) lv_at_lock <= n_lv + (bus.o_line_valid ? 1 : 0);
    lock_q <= bus.o_locked;
  end
  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic line(input int n);
    bus.i_end_line = 1'b1;
    step(1);
    bus.i_end_line = 1'b0;
    step(n - 1);
  endtask
  function automatic int outs();
    return int'({bus.o_line_len, bus.o_line_valid, bus.o_len_err, bus.o_timeout, bus.o_locked, bus.o_err_cnt});
  endfunction
  initial begin
    bus.i_mon_enb = 1'b1;
    bus.i_test = 1'b1;
    bus.i_end_line = 1'b1;
    step(5);
    chk("reset_outs", outs(), 0);
    rst_n = 1'b1;
    bus.i_mon_enb = 1'b0;
    bus.i_test = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.i_end_line = i[0];
      step(1);
    end
    bus.i_end_line = 1'b0;
    chk("idle_outs", outs(), 0);
    bus.i_mon_enb = 1'b1;
    step(1);
    lv0 = n_lv; le0 = n_le;
    for (int i = 0; i < 5; i++) line(4096);
    line(1000);
    chk("t2_valid_cnt", n_lv - lv0, 5);
    chk("t2_line_len", int'(last_len), 4095);
    chk("t2_lock_after", lv_at_lock - lv0, 4);
    chk("t2_locked", int'(bus.o_locked), 1);
    chk("t2_err_cnt", int'(bus.o_err_cnt), 0);
    chk("t2_len_err", n_le - le0, 0);
    line(4096);
    chk("t4_line_len", int'(last_len), 999);
    chk("t4_err_cnt", int'(bus.o_err_cnt), 1);
    chk("t4_len_err", n_le - le0, 1);
    chk("t4_unlocked", int'(bus.o_locked), 0);
    lv0 = n_lv;
    for (int i = 0; i < 4; i++) line(4096);
    chk("t4_relocked", int'(bus.o_locked), 1);
    chk("t4_relock_after", lv_at_lock - lv0, 4);
    lv0 = n_lv; to0 = n_to;
    chk("t5_no_early_to", int'(bus.o_timeout), 0);
    step(1);
    chk("t5_timeout", int'(bus.o_timeout), 1);
    chk("t5_len_err", int'(bus.o_len_err), 1);
    chk("t5_unlocked", int'(bus.o_locked), 0);
    chk("t5_err_cnt", int'(bus.o_err_cnt), 2);
    step(1);
    chk("t5_to_pulse", int'(bus.o_timeout), 0);
    step(5);
    line(2);
    chk("t5_realign_novalid", n_lv - lv0, 0);
    chk("t5_to_cnt", n_to - to0, 1);
    le0 = n_le; lv0 = n_lv;
    bus.i_test = 1'b1;
    step(2);
    for (int i = 0; i < 6; i++) line(16);
    chk("t3_valid_cnt", n_lv - lv0, 5);
    chk("t3_line_len", int'(last_len), 15);
    chk("t3_lock_after", lv_at_lock - lv0, 4);
    chk("t3_locked", int'(bus.o_locked), 1);
    chk("t3_len_err", n_le - le0, 0);
    bus.i_test = 1'b0;
    step(1);
    chk("t6_tchg_unlock", int'(bus.o_locked), 0);
    step(3);
    chk("t6_tchg_noerr", n_le - le0, 0);
    chk("t6_err_hold", int'(bus.o_err_cnt), 2);
    rst_n = 1'b0;
    step(1);
    chk("t6_midreset", outs(), 0);
    rst_n = 1'b1;
    bus.i_test = 1'b1;
    step(1);
    le0 = n_le;
    for (int i = 0; i < 301; i++) line(2);
    step(2);
    chk("t6_err_pulses", n_le - le0, 300);
    chk("t6_err_sat", int'(bus.o_err_cnt), 255);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
